// File: rtl/iob_pkg.sv
// Shared definitions for the IOB posted-write queue.
// Covers the 42-bit entry layout {RW,UDS,LDS,A,D} and the master FSM states.
package iob_pkg;
  localparam int ENTRY_W = 42;
  localparam int D_LSB   = 0;
  localparam int A_LSB   = 16;
  localparam int LDS_BIT = 39;
  localparam int UDS_BIT = 40;
  localparam int RW_BIT  = 41;

  typedef enum logic [1:0] {IDLE, REQ, ACT} ioState_t;

  function automatic logic [ENTRY_W-1:0] packEntry(input logic rw, input logic uds,
                                                   input logic lds, input logic [22:0] a,
                                                   input logic [15:0] d);
    return {rw, uds, lds, a, d};
  endfunction
endpackage

// File: rtl/iob_post_fifo.sv
// Circular entry store for the IOB posted-write queue.
// The head entry is read combinationally so the IOB master always sees it.
module iob_post_fifo
  import iob_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic               push,
  input  logic [ENTRY_W-1:0] pushData,
  input  logic               pop,
  output logic [ENTRY_W-1:0] headData,
  output logic               full,
  output logic               empty
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      rdPtr;
  logic [AW:0]        count;

  // Storage is not reset; only the pointers and count define valid entries.
  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/iob_post_queue.sv
// Posted-write queue between the FSB IO slave and the IOB master: writes are acked on entry,
// reads on IOB completion. Define IOB_BERR_STICKY_EN to latch posted-write bus errors.
module iob_post_queue
  import iob_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        S_REQ,
  input  logic        S_RW,
  input  logic [22:0] S_A,
  input  logic [15:0] S_D,
  input  logic        S_LDS,
  input  logic        S_UDS,
  output logic        S_RDY,
  output logic        S_BERR,
  output logic [15:0] S_Q,
  output logic        IOREQ,
  output logic        IORW,
  output logic [22:0] IOA,
  output logic [15:0] IOD,
  output logic        IOL,
  output logic        IOU,
  input  logic        IOACT,
  input  logic        IODONE,
  input  logic        IOBERR,
  input  logic [15:0] IOQ,
  output logic        EMPTY,
  output logic        FULL
`ifdef IOB_BERR_STICKY_EN
  ,
  output logic        BERR_STKY
`endif
);
  logic               pendValid;
  logic [ENTRY_W-1:0] pendEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               push;
  logic               pop;
  logic               dropWrite;
  logic               stickyErr;
  ioState_t           state;

`ifdef IOB_BERR_STICKY_EN
  assign stickyErr = BERR_STKY;
`else
  assign stickyErr = 1'b0;
`endif

  // A write arriving after a latched posted-write error is refused rather than queued.
  assign dropWrite = pendValid && !pendEntry[RW_BIT] && stickyErr;
  assign push      = pendValid && !fifoFull && !dropWrite;
  assign pop       = IODONE && ((state == REQ) || (state == ACT));

  iob_post_fifo #(.DEPTH(DEPTH), .AW(AW)) fifo (
    .CLK      (CLK),
    .RES      (RES),
    .push     (push),
    .pushData (pendEntry),
    .pop      (pop),
    .headData (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign IORW  = headEntry[RW_BIT];
  assign IOU   = headEntry[UDS_BIT];
  assign IOL   = headEntry[LDS_BIT];
  assign IOA   = headEntry[A_LSB +: 23];
  assign IOD   = headEntry[D_LSB +: 16];
  assign EMPTY = fifoEmpty && (state == IDLE);
  assign FULL  = fifoFull;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pendValid <= 1'b0;
      pendEntry <= '0;
      S_RDY     <= 1'b0;
      S_BERR    <= 1'b0;
      S_Q       <= '0;
      IOREQ     <= 1'b0;
      state     <= IDLE;
    end else begin
      S_RDY  <= 1'b0;
      S_BERR <= 1'b0;
      if (push || dropWrite) begin
        pendValid <= 1'b0;
      end else if (S_REQ && !pendValid) begin
        pendValid <= 1'b1;
        pendEntry <= packEntry(S_RW, S_UDS, S_LDS, S_A, S_D);
      end
      if (push && !pendEntry[RW_BIT]) S_RDY <= 1'b1;
      if (dropWrite) S_BERR <= 1'b1;
      // Reads terminate on the FSB only once the IOB has returned the data.
      if (pop && IORW) begin
        S_Q    <= IOQ;
        S_RDY  <= !IOBERR;
        S_BERR <= IOBERR;
      end
      case (state)
        IDLE: if (!fifoEmpty) begin
          state <= REQ;
          IOREQ <= 1'b1;
        end
        REQ: if (IODONE) begin
          state <= IDLE;
          IOREQ <= 1'b0;
        end else if (IOACT) begin
          state <= ACT;
          IOREQ <= 1'b0;
        end
        ACT: if (IODONE) state <= IDLE;
        default: begin
          state <= IDLE;
          IOREQ <= 1'b0;
        end
      endcase
    end
  end

`ifdef IOB_BERR_STICKY_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) BERR_STKY <= 1'b0;
    else if (pop && !IORW && IOBERR) BERR_STKY <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_iob_post_queue.sv
// Bench for iob_post_queue: directed scenarios plus randomized FSB traffic, checked against
// an in-order IO cycle model and a scoreboard of expected FSB acknowledges.
`timescale 1ns/1ps
module tb_iob_post_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        S_REQ, S_RW, S_LDS, S_UDS;
  logic [22:0] S_A;
  logic [15:0] S_D;
  logic        S_RDY, S_BERR;
  logic [15:0] S_Q;
  logic        IOREQ, IORW, IOL, IOU;
  logic [22:0] IOA;
  logic [15:0] IOD;
  logic        IOACT, IODONE, IOBERR;
  logic [15:0] IOQ;
  logic        EMPTY, FULL;
`ifdef IOB_BERR_STICKY_EN
  logic        BERR_STKY;
`endif

  always #5 CLK = ~CLK;

  iob_post_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RES(RES), .S_REQ(S_REQ), .S_RW(S_RW), .S_A(S_A), .S_D(S_D),
    .S_LDS(S_LDS), .S_UDS(S_UDS), .S_RDY(S_RDY), .S_BERR(S_BERR), .S_Q(S_Q),
    .IOREQ(IOREQ), .IORW(IORW), .IOA(IOA), .IOD(IOD), .IOL(IOL), .IOU(IOU),
    .IOACT(IOACT), .IODONE(IODONE), .IOBERR(IOBERR), .IOQ(IOQ),
    .EMPTY(EMPTY), .FULL(FULL)
`ifdef IOB_BERR_STICKY_EN
    , .BERR_STKY(BERR_STKY)
`endif
  );

  typedef struct packed {logic rw; logic uds; logic lds; logic [22:0] a; logic [15:0] d;} ioEnt_t;
  typedef struct {logic isRead; logic berr; logic [15:0] q; int issue; bit chkLat;} sbItem_t;
  typedef struct {logic berr; logic [15:0] q;} rdResp_t;

  ioEnt_t  ioModel[$];     // accepted IO cycles not yet completed on the IOB
  sbItem_t sb[$];          // expected FSB acknowledges, in order
  rdResp_t readResp[$];    // IOB responses chosen for queued reads
  int      readDoneLog[$];
  int      doneLog[$];

  int checks = 0, errors = 0, cycleCnt = 0, ackTotal = 0, lastAckCycle = 0;
  int iobMode = 0;         // 0 normal, 1 ignore IOREQ, 2 give IOACT but never IODONE
  bit forceWrBerr = 1'b0, stickyModel = 1'b0;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic fsbCycle(input logic rw, input logic [22:0] a, input logic [15:0] d,
                          input logic lds, input logic uds, input logic rdBerr,
                          input logic [15:0] rdQ);
    sbItem_t it;
    int n = 0;
    @(negedge CLK);
    it.isRead = rw;
    it.berr   = rw ? rdBerr : stickyModel;
    it.q      = rdQ;
    it.issue  = cycleCnt;
    it.chkLat = !rw && !stickyModel && (ioModel.size() < DEPTH);
    if (rw) readResp.push_back('{rdBerr, rdQ});
    if (rw || !stickyModel) ioModel.push_back('{rw, uds, lds, a, d});
    sb.push_back(it);
    S_REQ = 1'b1; S_RW = rw; S_A = a; S_D = d; S_LDS = lds; S_UDS = uds;
    @(negedge CLK);
    S_REQ = 1'b0;
    while (!(S_RDY || S_BERR) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no S_RDY/S_BERR for A=0x%06h, expected one within 300 cycles", a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((ioModel.size() != 0 || sb.size() != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d IO cycles outstanding, expected 0", ioModel.size());
    end
    repeat (3) @(negedge CLK);
    check("empty_after_drain", EMPTY, 1);
  endtask

  // FSB monitor: every acknowledge is matched against the scoreboard head.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RES && (S_RDY || S_BERR)) begin
        sbItem_t e;
        ackTotal++;
        lastAckCycle = cycleCnt;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got S_RDY=%0b S_BERR=%0b, expected no acknowledge", S_RDY, S_BERR);
        end else begin
          e = sb.pop_front();
          check("ack_kind", {S_RDY, S_BERR}, {!e.berr, e.berr});
          if (e.isRead && !e.berr) check("read_data", S_Q, e.q);
          if (e.chkLat) check("write_latency", cycleCnt - e.issue, 2);
          if (e.isRead) begin
            if (readDoneLog.size() == 0) begin
              checks++; errors++;
              $display("FAIL read_ack_early: got read ack at cycle %0d, expected it after IODONE", cycleCnt);
            end else begin
              check("read_latency", cycleCnt - readDoneLog.pop_front(), 1);
            end
          end
          $display("ack %0d: %s %s S_Q=0x%04h cycle %0d", ackTotal, e.isRead ? "read " : "write",
                   S_BERR ? "berr" : "rdy ", S_Q, cycleCnt);
        end
      end
    end
  end

  // IOB master model: completes each request and checks it is the oldest accepted cycle.
  initial begin
    ioEnt_t  ex, act;
    rdResp_t r;
    IOACT = 1'b0; IODONE = 1'b0; IOBERR = 1'b0; IOQ = '0;
    forever begin
      @(negedge CLK);
      IOACT = 1'b0; IODONE = 1'b0; IOBERR = 1'b0;
      if (!RES && iobMode != 1 && IOREQ) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        if (iobMode == 2 || $urandom_range(0, 3) != 0) begin
          IOACT = 1'b1;
          @(negedge CLK);
          IOACT = 1'b0;
          if (iobMode != 2) repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        if (iobMode != 2) begin
          act = {IORW, IOU, IOL, IOA, IOD};
          IOQ = 16'($urandom);
          if (ioModel.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_iob_cycle: got IO cycle A=0x%06h, expected none queued", IOA);
          end else begin
            ex = ioModel.pop_front();
            check("iob_entry", act, ex);
            if (ex.rw) begin
              if (readResp.size() != 0) begin
                r = readResp.pop_front();
                IOBERR = r.berr;
                IOQ    = r.q;
              end
              readDoneLog.push_back(cycleCnt);
            end else begin
`ifdef IOB_BERR_STICKY_EN
              IOBERR = forceWrBerr;
              if (forceWrBerr) stickyModel = 1'b1;
`else
              IOBERR = forceWrBerr || ($urandom_range(0, 3) == 0);
`endif
              forceWrBerr = 1'b0;
            end
          end
          IODONE = 1'b1;
          doneLog.push_back(cycleCnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within 500 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    S_REQ = 1'b0; S_RW = 1'b0; S_A = '0; S_D = '0; S_LDS = 1'b0; S_UDS = 1'b0;
    RES = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_s_rdy", S_RDY, 0);
    check("rst_s_berr", S_BERR, 0);
    check("rst_s_q", S_Q, 0);
    check("rst_ioreq", IOREQ, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    RES = 1'b0;
    repeat (2) @(negedge CLK);

    // Single posted write.
    fsbCycle(1'b0, 23'h0F7FF8, 16'hA55A, 1'b1, 1'b1, 1'b0, 16'h0);
    drain();

    // Fill the queue with the IOB stalled; the fifth write waits for a slot.
    iobMode = 1;
    for (int i = 0; i < 4; i++) fsbCycle(1'b0, 23'h000100 + 23'(i), 16'h1000 + 16'(i), 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge CLK);
    check("full_after_4", FULL, 1);
    snap = ackTotal;
    fork
      fsbCycle(1'b0, 23'h000104, 16'h1004, 1'b1, 1'b0, 1'b0, 16'h0);
      begin
        repeat (6) @(negedge CLK);
        check("fifth_withheld", ackTotal, snap);
        check("full_held", FULL, 1);
        doneLog.delete();
        iobMode = 0;
      end
    join
    @(negedge CLK);
    if (doneLog.size() == 0) begin
      checks++; errors++;
      $display("FAIL fifth_after_done: got no IODONE logged, expected one");
    end else begin
      check("fifth_after_done", lastAckCycle - doneLog[0], 2);
    end
    drain();

    // Two writes then a read: replay order and read data.
    fsbCycle(1'b0, 23'h000200, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0);
    fsbCycle(1'b0, 23'h000201, 16'hCAFE, 1'b0, 1'b1, 1'b0, 16'h0);
    fsbCycle(1'b1, 23'h0EFE00, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234);
    drain();

    // Read terminated by a bus error.
    fsbCycle(1'b1, 23'h000300, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hDEAD);
    drain();

    // Reset with the master in ACT and three entries queued.
    iobMode = 2;
    for (int i = 0; i < 3; i++) fsbCycle(1'b0, 23'h000500 + 23'(i), 16'h5000 + 16'(i), 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (3) @(negedge CLK);
    check("empty_before_reset", EMPTY, 0);
    #2 RES = 1'b1;
    #1;
    check("ioreq_on_reset", IOREQ, 0);
    check("empty_on_reset", EMPTY, 1);
    check("full_on_reset", FULL, 0);
    ioModel.delete(); readResp.delete(); readDoneLog.delete();
    @(negedge CLK);
    RES = 1'b0;
    iobMode = 0;
    fsbCycle(1'b0, 23'h000600, 16'h6666, 1'b1, 1'b1, 1'b0, 16'h0);
    drain();

`ifdef IOB_BERR_STICKY_EN
    // A posted-write bus error latches the sticky flag until reset.
    check("stky_clear", BERR_STKY, 0);
    forceWrBerr = 1'b1;
    fsbCycle(1'b0, 23'h000400, 16'h4444, 1'b1, 1'b1, 1'b0, 16'h0);
    drain();
    check("stky_set", BERR_STKY, 1);
    fsbCycle(1'b0, 23'h000401, 16'h4445, 1'b1, 1'b1, 1'b0, 16'h0);
    drain();
    #2 RES = 1'b1;
    #1;
    check("stky_reset", BERR_STKY, 0);
    stickyModel = 1'b0;
    @(negedge CLK);
    RES = 1'b0;
    repeat (2) @(negedge CLK);
`endif

    // Randomized traffic with random IOB timing and responses.
    for (int t = 0; t < 150; t++) begin
      fsbCycle(($urandom_range(0, 3) == 0), 23'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 4) == 0), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
